// File: rtl/mul_16_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and iteration count.
package mul_16_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mul_state_t;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned MUL_ITERS = MUL_WIDTH;

endpackage

// File: rtl/add_16.sv
// Ripple-free behavioural adder with carry-in and carry-out; default 16 bits wide.
module add_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] w_full;

    always_comb begin
        w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        sum    = w_full[WIDTH-1:0];
        c_out  = w_full[WIDTH];
    end

endmodule

// File: rtl/mul_16_seq.sv
// Sequential unsigned multiplier: one shift-add step per clock, WIDTH steps per
// product, with registered busy/done flags and a product held until the next start.
module mul_16_seq
    import mul_16_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mul_state_t         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CntW-1:0]    r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;

    // Multiplier LSB selects whether the multiplicand joins this step's partial sum.
    always_comb begin
        w_addend = r_acc[0] ? r_mcand : '0;
    end

    add_16 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a     (r_acc[2*WIDTH-1:WIDTH]),
        .b     (w_addend),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    // Carry lands in the MSB after the right shift, so no bit is lost.
                    r_acc <= {w_carry, w_sum, r_acc[WIDTH-1:1]};
                    if (r_cnt == LastCnt) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: tb/tb_mul_16_seq.sv
// Directed and random self-checking bench for mul_16_seq.
module tb_mul_16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_cmp;
    int n_fail;

    mul_16_seq #(
        .WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at the next edge, wait for done, sample product, then step back to IDLE.
    task automatic do_mul(input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] prod, output int lat);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        prod = product;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        n_cmp++;
        if (product !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_product: got %h want 00000000", product);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int          lat;
        a     = 16'd3;
        b     = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_run: got %b want 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 16", lat);
        end
        n_cmp++;
        if (product !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL basic_product: got %h want 0000000f", product);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_done: got %b want 1", busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy);
        end
        tick();
        tick();
        n_cmp++;
        if (product !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want 0000000f", product);
        end
        do_mul(16'd3, 16'd5, p, lat);
    endtask

    task automatic test_carry();
        logic [31:0] p;
        int          lat;
        do_mul(16'hFFFF, 16'hFFFF, p, lat);
        n_cmp++;
        if (p !== 32'hFFFE0001 || lat !== 16) begin
            n_fail++;
            $display("FAIL carry_ffff: got %h lat %0d want fffe0001 lat 16", p, lat);
        end
        do_mul(16'h0000, 16'h1234, p, lat);
        n_cmp++;
        if (p !== 32'h00000000) begin
            n_fail++;
            $display("FAIL zero_mcand: got %h want 00000000", p);
        end
        do_mul(16'h1234, 16'h0001, p, lat);
        n_cmp++;
        if (p !== 32'h00001234) begin
            n_fail++;
            $display("FAIL times_one: got %h want 00001234", p);
        end
    endtask

    // Operands scramble every RUN cycle; start pulses in RUN and in DONE must be ignored.
    task automatic test_operand_change();
        int lat;
        a     = 16'h8000;
        b     = 16'h0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            start = (lat == 5);
            tick();
            lat++;
        end
        start = 1'b0;
        n_cmp++;
        if (product !== 32'h00010000 || lat !== 16) begin
            n_fail++;
            $display("FAIL operand_change: got %h lat %0d want 00010000 lat 16", product, lat);
        end
        a     = 16'h0009;
        b     = 16'h0009;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || product !== 32'h00010000) begin
            n_fail++;
            $display("FAIL start_in_done: got busy=%b prod=%h want 0 00010000", busy, product);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int first;
        int second;
        first  = -1;
        second = -1;
        cyc    = 0;
        a      = 16'd3;
        b      = 16'd7;
        start  = 1'b1;
        while (second < 0 && cyc < 80) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (second - first !== 18 || first !== 17) begin
            n_fail++;
            $display("FAIL back_to_back: got first=%0d second=%0d want 17 35", first, second);
        end
        n_cmp++;
        if (product !== 32'd21) begin
            n_fail++;
            $display("FAIL back_to_back_product: got %h want 00000015", product);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        int          lat;
        int          seen;
        a     = 16'd5;
        b     = 16'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b prod=%h want 0 0 0", busy, done,
                     product);
        end
        seen = 0;
        repeat (3) begin
            tick();
            if (done === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            if (done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d pulses want 0", seen);
        end
        do_mul(16'd7, 16'd9, p, lat);
        n_cmp++;
        if (p !== 32'h0000003F || lat !== 16) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat %0d want 0000003f lat 16", p, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] p;
        logic [31:0] expv;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            av   = 16'($urandom);
            bv   = 16'($urandom);
            expv = {16'h0, av} * {16'h0, bv};
            do_mul(av, bv, p, lat);
            n_cmp++;
            if (p !== expv || lat !== 16) begin
                n_fail++;
                $display("FAIL random_%0d: %h*%h got %h lat %0d want %h lat 16", i, av, bv, p,
                         lat, expv);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_carry();
        test_operand_change();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_16_seq.md
MUL_16_SEQ -- requirements
Module: mul_16_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; the product is 2*WIDTH bits wide.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  multiplicand, unsigned; sampled on the start-accept edge.
REQ-006 Port: b  input  WIDTH  multiplier, unsigned; sampled on the start-accept edge.
REQ-007 Port: busy  output  1  high in RUN and DONE.
REQ-008 Port: done  output  1  high for exactly one cycle, in DONE.
REQ-009 Port: product  output  2*WIDTH  unsigned a*b, registered.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-011 IDLE->RUN SHALL occur on an edge with start=1: a goes to the mcand register, b to the low half of acc, high half of acc cleared, iteration counter cleared.
REQ-012 Each RUN edge SHALL perform one shift-add step: if acc[0]=1, {carry,sum} = acc_hi + mcand (WIDTH-bit add with carry-out), else {carry,sum} = {0,acc_hi}; then acc <= {carry,sum,acc_lo} >> 1; counter += 1.
REQ-013 RUN SHALL last exactly WIDTH edges; on the edge where counter = WIDTH-1, state SHALL go to DONE.
REQ-014 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-015 Latency: start accepted at edge k means done=1 in the cycle after edge k+WIDTH (k+16 for default), and state is IDLE after edge k+WIDTH+1.
REQ-016 product SHALL equal acc; it is valid while done=1 and SHALL hold that value until the next start is accepted.
REQ-017 start while busy=1, including in DONE, SHALL be ignored, with no effect on state or operands.
REQ-018 Changes on a or b after the accept edge SHALL not affect the result.
REQ-019 The carry-out SHALL never be discarded: the full 2*WIDTH result is exact for all unsigned inputs, including the 0xFFFF*0xFFFF case.
REQ-020 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap while in RUN.

Reset
REQ-021 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, go to IDLE with busy=0, done=0, product=0, counter=0, and mcand=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL begin a fresh multiply.
REQ-023 Reset SHALL be deasserted synchronously to clk by the integrating logic; the block contains no reset synchronizer.

Structure
REQ-024 The shared arithmetic package SHALL hold: the state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the default WIDTH, and the iteration-count constant.
REQ-025 The per-step addition SHALL instantiate the existing 16-bit adder sub-module add_16 (carry-in tied 0, c_out used as carry), not a separate inline adder.
REQ-026 busy and done SHALL be decoded from the state register and be glitch-free; product SHALL come directly from acc.
REQ-027 The implementation SHALL have no other sub-modules.

Verification
REQ-028 Reset, then a=3, b=5, start=1 for one cycle -> done=1 exactly 16 edges after accept; product=0x0000000F; busy low afterwards.
REQ-029 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 (carry path); then a=0x0000, b=0x1234 -> product=0x00000000.
REQ-030 a=0x8000, b=0x0002 -> product=0x00010000; change a and b every cycle during RUN -> result unchanged.
REQ-031 start held high continuously -> each multiply is spaced 18 cycles apart (accept, 16 RUN, DONE, then re-accept from IDLE); a pulse of start during RUN or DONE is ignored.
REQ-032 rst_n low at RUN step 7 -> busy, done, and product go to 0 immediately with no done pulse; a new multiply of 7*9 then gives product=0x0000003F.
REQ-033 A random self-checking loop of at least 1000 operand pairs -> product == a*b on every done pulse.
